// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the program counter, issues sequential word fetches over a valid/ready
// request channel and buffers in-order responses in a DEPTH-entry prefetch
// queue that feeds decode. A redirect flushes the queue and discards the
// responses of requests that were still in flight.
// Optional feature: define FETCH_BYPASS_EN to let a response go straight to
// decode in the same cycle when the queue is empty.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   hold_inst;
  logic [31:0]   hold_pc;

  logic [CW+1:0] occupancy;
  logic [31:0]   redirect_target;
  logic          accept;
  logic          live_resp;
  logic          q_empty;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          unused_low_bits;

  // Target addresses are word aligned; the low two bits are dropped.
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

  // Every slot is reserved at issue time: live and stale requests in flight
  // plus queued entries may never exceed DEPTH, so a push never overflows.
  assign occupancy      = {2'b00, inflight} + {2'b00, discard} + {2'b00, count};
  assign imem_req_valid = !reset && !redirect && (occupancy < (CW+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response is live only when no stale responses remain ahead of it and
  // the same cycle is not being flushed.
  assign live_resp = imem_resp_valid && (discard == '0) && !redirect;
  assign q_empty   = (count == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = q_empty && live_resp && !reset;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid = !q_empty || bypass;
  assign pop        = !q_empty && inst_ready;
  assign push       = live_resp && !(bypass && inst_ready);

  // Head of queue, else a bypassed response, else the last value shown.
  always_comb begin
    inst    = hold_inst;
    inst_pc = hold_pc;
    if (!q_empty) begin
      inst    = q_inst[rd_ptr];
      inst_pc = q_pc[rd_ptr];
    end else if (bypass) begin
      inst    = imem_resp_data;
      inst_pc = resp_pc;
    end
  end

  // Control state: PCs, counters, queue pointers and the held output value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      inflight  <= '0;
      discard   <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      hold_inst <= '0;
      hold_pc   <= '0;
    end else begin
      if (inst_valid) begin
        hold_inst <= inst;
        hold_pc   <= inst_pc;
      end
      if (redirect) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        discard  <= discard + inflight - CW'(imem_resp_valid);
        inflight <= '0;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (live_resp) begin
          resp_pc <= resp_pc + 32'd4;
        end
        inflight <= inflight + CW'(accept) - CW'(live_resp);
        discard  <= discard - CW'(imem_resp_valid && (discard != '0));
        count    <= count + CW'(push) - CW'(pop);
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // Queue storage holds data only, so it carries no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]   <= resp_pc;
      q_inst[wr_ptr] <= imem_resp_data;
    end
  end

endmodule
